des_sbox_sequencer: RTL and testbench



---
 rtl/des_sbox_sequencer.sv | 127 ++++++++++++
 tb/tb_des_sbox_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_sbox_sequencer.sv
// DES S-layer sequencer: walks a 48-bit word through eight registered S-box lanes, one 6-bit chunk per cycle.
// Define DES_SBOX_SEQ_PERM_EN to apply the DES P-permutation to Data_Out.
module des_sbox_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [47:0] Data_In,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] Data_Out,
  output logic [5:0]  Sbox_Input,
  output logic [7:0]  Sbox_Select,
  input  logic [31:0] Sbox_Output,
  input  logic [7:0]  Sbox_Finish
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state;
  logic [47:0] word;
  logic [2:0]  lane;
  logic [31:0] acc;
  logic [2:0]  cap_lane;
  logic        cap_ok;
  logic [31:0] acc_cap;

  // Six-bit chunk for lane idx (0 = S1 = DES bits 1..6)
  function automatic logic [5:0] chunk(input logic [47:0] w, input logic [2:0] idx);
    return w[6'(47 - 6 * int'(idx)) -: 6];
  endfunction

`ifdef DES_SBOX_SEQ_PERM_EN
  localparam int unsigned P [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                      1, 15, 23, 26,  5, 18, 31, 10,
                                      2,  8, 24, 14, 32, 27,  3,  9,
                                     19, 13, 30,  6, 22, 11,  4, 25};

  // Output DES bit i takes accumulator DES bit P[i]; DES bit n sits at index 32-n
  function automatic logic [31:0] out_map(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    for (int i = 1; i <= 32; i++) r[5'(32 - i)] = a[5'(32 - int'(P[i-1]))];
    return r;
  endfunction
`else
  function automatic logic [31:0] out_map(input logic [31:0] a);
    return a;
  endfunction
`endif

  // Lanes answer one cycle after selection, so the lane due now is the previous issue
  assign cap_lane = (state == DRAIN) ? 3'd7 : 3'(lane - 3'd1);
  assign cap_ok   = Sbox_Finish[cap_lane];

  always_comb begin
    acc_cap = acc;
    acc_cap[5'(31 - 4 * int'(cap_lane)) -: 4] = Sbox_Output[5'(31 - 4 * int'(cap_lane)) -: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word        <= '0;
      lane        <= '0;
      acc         <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Error       <= 1'b0;
      Data_Out    <= '0;
      Sbox_Select <= '0;
      Sbox_Input  <= '0;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            word        <= Data_In;
            lane        <= 3'd0;
            acc         <= '0;
            Sbox_Select <= 8'd1;
            Sbox_Input  <= chunk(Data_In, 3'd0);
            Busy        <= 1'b1;
            state       <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (lane != 3'd0 && !cap_ok) begin
            Error       <= 1'b1;
            Busy        <= 1'b0;
            Sbox_Select <= '0;
            Sbox_Input  <= '0;
            state       <= IDLE;
          end else begin
            if (lane != 3'd0) acc <= acc_cap;
            if (lane == 3'd7) begin
              Sbox_Select <= '0;
              Sbox_Input  <= '0;
              state       <= DRAIN;
            end else begin
              lane        <= 3'(lane + 3'd1);
              Sbox_Select <= Sbox_Select << 1;
              Sbox_Input  <= chunk(word, 3'(lane + 3'd1));
            end
          end
        end
        DRAIN: begin
          Busy <= 1'b0;
          if (!cap_ok) begin
            Error <= 1'b1;
            state <= IDLE;
          end else begin
            acc      <= acc_cap;
            Data_Out <= out_map(acc_cap);
            Done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Scoreboard bench for des_sbox_sequencer with behavioural registered DES S-box lanes.
// Honours DES_SBOX_SEQ_PERM_EN the same way as the design.
module tb_des_sbox_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [47:0] data_in = '0;
  logic        busy, done, error;
  logic [31:0] data_out;
  logic [5:0]  sbox_input;
  logic [7:0]  sbox_select;
  logic [31:0] sbox_output = '0;
  logic [7:0]  sbox_finish = '0;

  des_sbox_sequencer dut (
    .clk(clk), .rst(rst), .Start(start), .Data_In(data_in),
    .Busy(busy), .Done(done), .Error(error), .Data_Out(data_out),
    .Sbox_Input(sbox_input), .Sbox_Select(sbox_select),
    .Sbox_Output(sbox_output), .Sbox_Finish(sbox_finish)
  );

  always #5 clk = ~clk;

  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };
  localparam int P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                            2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
`ifdef DES_SBOX_SEQ_PERM_EN
  localparam logic [31:0] ZERO_EXP = 32'hD8D8DBBC;
`else
  localparam logic [31:0] ZERO_EXP = 32'hEFA72C4D;
`endif

  // Row from the outer bits, column from the middle four
  function automatic logic [3:0] sbox_val(input int b, input logic [5:0] c);
    return 4'(SB[b][int'({c[5], c[0]}) * 16 + int'(c[4:1])]);
  endfunction

  function automatic logic [31:0] ref_f(input logic [47:0] w);
    logic [31:0] raw, r;
    for (int i = 0; i < 8; i++) raw[31 - 4*i -: 4] = sbox_val(i, w[47 - 6*i -: 6]);
`ifdef DES_SBOX_SEQ_PERM_EN
    for (int i = 1; i <= 32; i++) r[32 - i] = raw[32 - P[i-1]];
`else
    r = raw;
`endif
    return r;
  endfunction

  // Behavioural lanes: answer one cycle after select; fail_lane suppresses one finish
  int fail_lane = -1;
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (sbox_select[i] && fail_lane != i) begin
        sbox_finish[i] <= 1'b1;
        sbox_output[31 - 4*i -: 4] <= sbox_val(i, sbox_input);
      end else begin
        sbox_finish[i] <= 1'b0;
      end
    end
  end

  typedef struct { bit is_err; int cyc; logic [31:0] data; } exp_t;
  exp_t q[$];

  int          n_tests = 0, n_fail = 0, cyc = 0, done_cnt = 0;
  int          cur_c0 = -1000, sel_len = 0, busy_len = 0;
  logic [47:0] cur_word = '0;
  logic [31:0] last_good = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle select/input/busy trace plus scoreboard pops on Done/Error
  always @(negedge clk) begin
    int off;
    logic [7:0] es;
    logic [5:0] ei;
    exp_t e;
    off = cyc - cur_c0;
    es = '0;
    ei = '0;
    if (off >= 0 && off < sel_len) begin
      es = 8'(1) << off;
      ei = cur_word[47 - 6*off -: 6];
    end
    check("sbox_select", sbox_select, es);
    check("sbox_input", sbox_input, ei);
    check("busy", busy, (off >= 0 && off < busy_len) ? 1 : 0);
    if (done || error) begin
      if (done) done_cnt++;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got done=%0b error=%0b expected none (cycle %0d)", done, error, cyc);
      end else begin
        e = q.pop_front();
        check("pulse_kind", {done, error}, e.is_err ? 2'b01 : 2'b10);
        check("pulse_cycle", cyc, e.cyc);
        check("data_out", data_out, e.data);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d pending events expected 0", q.size());
      q.delete();
    end
    fail_lane = -1;
  endtask

  // One transaction; f >= 0 withholds finish on 0-based lane f
  task automatic run_op(input logic [47:0] w, input int f);
    int c0;
    exp_t e;
    @(negedge clk);
    data_in = w;
    start = 1'b1;
    fail_lane = f;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    cur_word = w;
    cur_c0 = c0;
    if (f >= 0) begin
      sel_len = (f + 2 > 8) ? 8 : f + 2;
      busy_len = f + 2;
      e = '{1'b1, c0 + f + 2, last_good};
    end else begin
      sel_len = 8;
      busy_len = 9;
      last_good = ref_f(w);
      e = '{1'b0, c0 + 9, last_good};
    end
    q.push_back(e);
    wait_idle();
  endtask

  task automatic run_held(input logic [47:0] w);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    data_in = w;
    start = 1'b1;
    last_good = ref_f(w);
    @(posedge clk);
    for (int n = 0; n < 3; n++) begin
      #1;
      cur_word = w;
      cur_c0 = cyc;
      sel_len = 8;
      busy_len = 9;
      q.push_back('{1'b0, cyc + 9, last_good});
      if (n < 2) repeat (10) @(posedge clk);
    end
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (15) @(negedge clk);
    check("held_done_count", done_cnt - d0, 3);
  endtask

  task automatic run_reset_abort(input logic [47:0] w);
    @(negedge clk);
    data_in = w;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cur_word = w;
    cur_c0 = cyc;
    sel_len = 5;
    busy_len = 5;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    check("abort_data_out", data_out, 0);
    check("abort_select", sbox_select, 0);
    check("abort_input", sbox_input, 0);
    rst = 1'b0;
    last_good = '0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic [47:0] w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_data_out", data_out, 0);
    check("reset_select", sbox_select, 0);
    check("reset_input", sbox_input, 0);
    rst = 1'b0;

    run_op(48'h0, -1);
    check("zero_vector", data_out, ZERO_EXP);
    run_op(48'hFFFF_FFFF_FFFF, -1);
    run_op(48'(({$urandom(), $urandom()})), 2);
    check("error_keeps_data_out", data_out, last_good);
    run_op(48'(({$urandom(), $urandom()})), 0);
    run_op(48'(({$urandom(), $urandom()})), 7);
    run_held(48'(({$urandom(), $urandom()})));
    run_reset_abort(48'(({$urandom(), $urandom()})));
    run_op(48'h0123_4567_89AB, -1);
    for (int i = 0; i < 16; i++) begin
      w = 48'(({$urandom(), $urandom()}));
      run_op(w, (i % 5 == 4) ? int'($urandom_range(0, 7)) : -1);
    end
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
